// File: rtl/key_sched_seq.sv
// key_sched_seq: sequential round-key generator rotating {C,D} halves in forward or reverse round order
module key_sched_seq #(
  parameter int HALF_W = 28,
  parameter int ROUNDS = 16,
  parameter logic [ROUNDS-1:0] SHIFT1_MASK = 16'h8103
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       decrypt,
  input  logic                       abort,
  input  logic [2*HALF_W-1:0]        key_in,
  input  logic                       rk_ready,
  output logic                       rk_valid,
  output logic [2*HALF_W-1:0]        rk_out,
  output logic [$clog2(ROUNDS)-1:0]  rk_idx,
  output logic                       busy,
  output logic                       done
);
  localparam int IW = $clog2(ROUNDS);
  localparam logic [IW-1:0] LAST = IW'(ROUNDS - 1);

  function automatic int total_shift();
    int t = 0;
    for (int r = 0; r < ROUNDS; r++) t += SHIFT1_MASK[r] ? 1 : 2;
    return t;
  endfunction

  localparam int TOT = total_shift() % HALF_W;

  function automatic int sh(input logic [IW-1:0] r);
    return SHIFT1_MASK[r] ? 1 : 2;
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input int n);
    return (x << n) | (x >> (HALF_W - n));
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input int n);
    return (x >> n) | (x << (HALF_W - n));
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, nxt;
  logic              dec, load, step, last;
  logic [HALF_W-1:0] c, d;
  logic [IW-1:0]     idx;

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  // next state: abort beats the handshake, start with abort is ignored
  always_comb begin
    last = dec ? (idx == '0) : (idx == LAST);
    load = state == IDLE && start && !abort;
    step = state == RUN && !abort && rk_ready;
    nxt  = state == DONE ? IDLE :
           load ? RUN :
           (state == RUN && abort) ? IDLE :
           (step && last) ? DONE : state;
  end

  // key halves and round index; decrypt starts from the fully rotated key and walks back
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c   <= '0;
      d   <= '0;
      idx <= '0;
      dec <= 1'b0;
    end else if (load) begin
      dec <= decrypt;
      idx <= decrypt ? LAST : '0;
      c   <= rotl(key_in[2*HALF_W-1:HALF_W], decrypt ? TOT : sh('0));
      d   <= rotl(key_in[HALF_W-1:0], decrypt ? TOT : sh('0));
    end else if (step && !last) begin
      idx <= dec ? idx - IW'(1) : idx + IW'(1);
      c   <= dec ? rotr(c, sh(idx)) : rotl(c, sh(idx + IW'(1)));
      d   <= dec ? rotr(d, sh(idx)) : rotl(d, sh(idx + IW'(1)));
    end

  assign rk_valid = state == RUN;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign rk_out   = {c, d};
  assign rk_idx   = idx;
endmodule

// File: tb/tb_key_sched_seq.sv
// tb_key_sched_seq: directed self-checking bench for key_sched_seq at default and swept parameters
module tb_key_sched_seq;
  logic clk = 1'b0, rst_n = 1'b1;
  logic start, decrypt, abort, rk_ready;
  logic [55:0] key_in, rk_out;
  logic rk_valid, busy, done;
  logic [3:0] rk_idx;
  logic start2, dec2, ready2;
  logic [63:0] key2, ro2;
  logic rv2, busy2, done2;
  logic [2:0] ri2;
  int errors = 0, checks = 0;
  int k;
  logic hs, stalled;
  logic [55:0] prev;
  logic [63:0] m1 [16];
  logic [63:0] m2 [8];
  localparam logic [55:0] K = {28'h0000001, 28'h8000000};

  always #5 clk = ~clk;

  key_sched_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .abort(abort),
    .key_in(key_in), .rk_ready(rk_ready), .rk_valid(rk_valid), .rk_out(rk_out), .rk_idx(rk_idx),
    .busy(busy), .done(done));

  key_sched_seq #(.HALF_W(32), .ROUNDS(8), .SHIFT1_MASK(8'h0F)) dut2 (.clk(clk), .rst_n(rst_n),
    .start(start2), .decrypt(dec2), .abort(1'b0), .key_in(key2), .rk_ready(ready2), .rk_valid(rv2),
    .rk_out(ro2), .rk_idx(ri2), .busy(busy2), .done(done2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mdl(input logic [63:0] key, input int w, input logic [63:0] mask, input int r);
    logic [63:0] m = (64'd1 << w) - 64'd1;
    logic [63:0] c = (key >> w) & m;
    logic [63:0] d = key & m;
    int s = 0;
    for (int i = 0; i <= r; i++) s += mask[i] ? 1 : 2;
    for (int j = 0; j < s; j++) begin
      c = ((c << 1) | (c >> (w - 1))) & m;
      d = ((d << 1) | (d >> (w - 1))) & m;
    end
    return (c << w) | d;
  endfunction

  initial begin
    start = 0; decrypt = 0; abort = 0; rk_ready = 1; key_in = K;
    start2 = 0; dec2 = 0; ready2 = 1; key2 = {32'h80000001, 32'h12345678};
    for (int i = 0; i < 16; i++) m1[i] = mdl({8'h0, K}, 28, 64'h8103, i);
    for (int i = 0; i < 8; i++) m2[i] = mdl(key2, 32, 64'h0F, i);
    #1 rst_n = 0;
    #1;
    chk("rst_valid", rk_valid, 0); chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    chk("rst_out", rk_out, 0); chk("rst_idx", rk_idx, 0); chk("rst_valid2", rv2, 0);
    #10 rst_n = 1;
    tick();
    start = 1; tick(); start = 0;
    chk("enc_rk0", rk_out, {28'h0000002, 28'h0000001});
    for (int i = 0; i < 16; i++) begin
      chk("enc_valid", rk_valid, 1); chk("enc_idx", rk_idx, i); chk("enc_out", rk_out, m1[i]);
      if (i == 1) chk("enc_rk1", rk_out, {28'h0000004, 28'h0000002});
      if (i == 2) chk("enc_rk2", rk_out, {28'h0000010, 28'h0000008});
      if (i == 15) chk("enc_rk15", rk_out, {28'h0000001, 28'h8000000});
      tick();
    end
    chk("enc_done", done, 1); chk("enc_done_valid", rk_valid, 0); chk("enc_done_busy", busy, 1);
    tick();
    chk("enc_done_pulse", done, 0); chk("enc_idle_busy", busy, 0);
    start = 1; decrypt = 1; tick(); start = 0; decrypt = 0;
    chk("dec_first", rk_out, {28'h0000001, 28'h8000000}); chk("dec_first_idx", rk_idx, 15);
    for (int j = 0; j < 16; j++) begin
      chk("dec_idx", rk_idx, 15 - j); chk("dec_out", rk_out, m1[15 - j]);
      if (j == 1) chk("dec_second", rk_out, {28'h8000000, 28'h4000000});
      tick();
    end
    chk("dec_done", done, 1);
    tick();
    start = 1; tick(); start = 0;
    k = 0; stalled = 0; prev = '0;
    for (int cyc = 0; cyc < 400 && k < 16; cyc++) begin
      chk("bp_idx", rk_idx, k); chk("bp_out", rk_out, m1[k]);
      if (stalled) chk("bp_stable", rk_out, prev);
      rk_ready = 1'($urandom_range(0, 1));
      hs = rk_valid && rk_ready;
      prev = rk_out;
      stalled = !rk_ready;
      tick();
      if (hs) k++;
    end
    chk("bp_count", k, 16); chk("bp_done", done, 1);
    rk_ready = 1;
    tick();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 6; i++) begin
      chk("ign_idx", rk_idx, i); chk("ign_out", rk_out, m1[i]);
      start = i == 3; key_in = i == 3 ? ~K : K; abort = i == 5;
      tick();
    end
    start = 0; abort = 0; key_in = K;
    chk("abort_valid", rk_valid, 0); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    tick();
    chk("abort_nodone", done, 0);
    start = 1; abort = 1; tick();
    chk("start_abort_idle", busy, 0);
    abort = 0; tick(); start = 0;
    chk("restart_valid", rk_valid, 1); chk("restart_idx", rk_idx, 0); chk("restart_out", rk_out, m1[0]);
    tick(); tick();
    #2 rst_n = 0;
    #1;
    chk("midrst_valid", rk_valid, 0); chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
    chk("midrst_out", rk_out, 0); chk("midrst_idx", rk_idx, 0);
    #3 rst_n = 1;
    tick();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 16; i++) begin
      chk("rerun_idx", rk_idx, i); chk("rerun_out", rk_out, m1[i]);
      tick();
    end
    chk("rerun_done", done, 1);
    start2 = 1; tick(); start2 = 0;
    chk("p_enc_rk0", ro2, {32'h00000003, 32'h2468ACF0});
    for (int i = 0; i < 8; i++) begin
      chk("p_enc_idx", ri2, i); chk("p_enc_out", ro2, m2[i]);
      tick();
    end
    chk("p_enc_done", done2, 1);
    tick();
    start2 = 1; dec2 = 1; tick(); start2 = 0; dec2 = 0;
    chk("p_dec_first", ro2, {32'h00001800, 32'h45678123}); chk("p_dec_first_idx", ri2, 7);
    for (int j = 0; j < 8; j++) begin
      chk("p_dec_idx", ri2, 7 - j); chk("p_dec_out", ro2, m2[7 - j]);
      tick();
    end
    chk("p_dec_done", done2, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_sched_seq.md
KEY_SCHED_SEQ -- requirements
Module: key_sched_seq

Interface
REQ-001 SHALL have parameter HALF_W, default 28, the width of each key half (C and D).
REQ-002 SHALL have parameter ROUNDS, default 16, the number of round keys issued per run (2..64).
REQ-003 SHALL have parameter SHIFT1_MASK, ROUNDS bits wide, default 16'h8103: bit r=1 gives round r a rotation of 1, bit r=0 gives a rotation of 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, a run request, sampled only in IDLE.
REQ-007 SHALL have port decrypt, input, 1, mode, sampled with start: 0 gives forward order, 1 gives reverse order.
REQ-008 SHALL have port abort, input, 1, synchronous cancel of the current run.
REQ-009 SHALL have port key_in, input, 2*HALF_W, the pre-permuted key: C in the upper half, D in the lower half.
REQ-010 SHALL have port rk_ready, input, 1, the consumer accepts rk_out.
REQ-011 SHALL have port rk_valid, output, 1, rk_out holds a valid round key.
REQ-012 SHALL have port rk_out, output, 2*HALF_W, the rotated {C,D} for the current round.
REQ-013 SHALL have port rk_idx, output, clog2(ROUNDS), the encryption round number of rk_out.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse after the last round key is accepted.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE; IDLE --start&!abort--> RUN; RUN --last handshake--> DONE; DONE --next cycle--> IDLE; RUN --abort--> IDLE.
REQ-017 SHALL define shift(r) = 1 if SHIFT1_MASK[r], else 2, and TOTAL = sum over r of shift(r), evaluated at elaboration.
REQ-018 Encrypt mode: in the cycle after start is accepted, rk_out SHALL be {rotl(C0,shift(0)), rotl(D0,shift(0))}, with rk_idx=0.
REQ-019 Encrypt mode: on each handshake (rk_valid&rk_ready) with rk_idx=k<ROUNDS-1, the next cycle SHALL give rk_out = each half of rk_out rotated left by shift(k+1), with rk_idx=k+1.
REQ-020 Decrypt mode: the first rk_out SHALL be each half of key_in rotated left by (TOTAL mod HALF_W), with rk_idx=ROUNDS-1.
REQ-021 Decrypt mode: on each handshake with rk_idx=k>0, the next cycle SHALL give rk_out = each half rotated right by shift(k), with rk_idx=k-1.
REQ-022 Rotations SHALL act on each HALF_W half independently; no bits SHALL cross between C and D.
REQ-023 rk_valid SHALL be high throughout RUN; rk_out and rk_idx SHALL stay stable while rk_valid&!rk_ready.
REQ-024 Throughput SHALL be one key per cycle with rk_ready held high; ROUNDS keys SHALL occupy exactly ROUNDS cycles.
REQ-025 The handshake of the final key (rk_idx=ROUNDS-1 in encrypt mode, 0 in decrypt mode) SHALL drop rk_valid next cycle and enter DONE, where done=1 for one cycle.
REQ-026 start SHALL be ignored outside IDLE; key_in and decrypt SHALL be ignored except when start is accepted.
REQ-027 abort in RUN SHALL return to IDLE next cycle with rk_valid=0 and no done pulse; abort SHALL take priority over a simultaneous handshake.
REQ-028 start together with abort in IDLE SHALL be ignored.
REQ-029 start may be accepted in the IDLE cycle immediately after DONE.

Reset
REQ-030 rst_n low SHALL immediately force IDLE with rk_valid=0, done=0, busy=0, rk_out=0 and rk_idx=0, independent of clk, including in the middle of a run.
REQ-031 After rst_n is released, the first start SHALL be accepted no earlier than the next rising edge.

Verification
REQ-032 Encrypt, defaults, C0=28'h0000001, D0=28'h8000000, rk_ready=1: rk0 = {0000002,0000001}, rk1 = {0000004,0000002}, rk2 = {0000010,0000008}, rk15 = {0000001,8000000}; done pulses 1 cycle after rk15.
REQ-033 Decrypt, same key: the first key is {0000001,8000000} with rk_idx=15, the second is {8000000,4000000} with rk_idx=14, and the last has rk_idx=0.
REQ-034 Backpressure: rk_ready toggles 0/1 randomly; the key sequence SHALL match the REQ-032 model and output SHALL stay stable while stalled.
REQ-035 Assert start during RUN with a new key: it is ignored and the sequence is unchanged. abort at rk_idx=5 gives IDLE, no done pulse, and a new start is accepted.
REQ-036 Pulse rst_n low mid-run, between clock edges: outputs SHALL be 0 immediately, and a restart SHALL produce the full 16-key sequence.
REQ-037 Parameter sweep HALF_W=32, ROUNDS=8, SHIFT1_MASK=8'h0F: encrypt and decrypt sequences SHALL match a software model, with a decrypt start rotation of 12.
